// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared definitions for the programmable sequence detector.
//   DEFAULT_PATTERN / DEFAULT_LEN : configuration loaded at reset
//   mode_e                        : overlapping / non-overlapping detection
//   len_legal()                   : 1 <= len <= max
package seq_detect_pkg;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1101;
    localparam int         DEFAULT_LEN     = 4;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } mode_e;

    function automatic logic len_legal(input int unsigned len, input int unsigned max);
        if ((len >= 32'd1) && (len <= max)) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : count one event this cycle
//   cnt      : registered count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    import seq_detect_pkg::*;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time programmable serial bit-sequence detector.
//   clk, rst    : clock, asynchronous active-high reset
//   din         : serial bit, sampled when din_valid is high
//   overlap     : 1 = overlapping detection, 0 = restart after each match
//   cfg_we      : load cfg_pattern / cfg_len (a din in the same cycle is dropped)
//   cfg_pattern : pattern, bit [len-1] received first, bit [0] last
//   cfg_len     : pattern length, legal range 1..MAX_LEN
//   cnt_clr     : synchronous clear of match_cnt
//   match       : combinational Mealy match, same cycle as the final bit
//   match_cnt   : saturating match count
//   enabled     : registered, high while the loaded length is legal
module seq_detect_param #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(seq_detect_pkg::DEFAULT_PATTERN),
    parameter int                 DEFAULT_LEN     = seq_detect_pkg::DEFAULT_LEN,
    localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               overlap,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               enabled
);
    import seq_detect_pkg::*;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               enabled_q, enabled_d;

    logic [MAX_LEN:0]   window_s;
    logic [MAX_LEN:0]   mask_s;
    logic               accept_s;
    logic               fill_ok_s;
    logic               hit_s;
    logic               match_s;
    mode_e              mode_s;

    assign mode_s   = mode_e'(overlap);
    assign accept_s = din_valid & ~cfg_we;
    // Current bit sits in bit 0, so the oldest bit of a len-bit window is window[len-1].
    assign window_s = {hist_q, din};

    // Compare mask: the low len bits of the window take part in the match.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // fill >= len-1, evaluated one bit wider so len = 0 cannot underflow.
    assign fill_ok_s = ({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q};
    assign hit_s     = ((window_s ^ {1'b0, pat_q}) & mask_s) == '0;
    assign match_s   = accept_s & enabled_q & fill_ok_s & hit_s;
    assign match     = match_s;

    // Next configuration / history / fill.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        enabled_d = enabled_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (cfg_we) begin
            pat_d     = cfg_pattern;
            len_d     = cfg_len;
            enabled_d = len_legal(32'(cfg_len), 32'(MAX_LEN));
            fill_d    = '0;
        end else if (accept_s) begin
            hist_d = {hist_q[MAX_LEN-2:0], din};
            if (match_s && (mode_s == NON_OVERLAP)) begin
                // Non-overlapping: the matched bits may not be reused.
                fill_d = '0;
            end else if (fill_q >= LEN_W'(MAX_LEN)) begin
                fill_d = LEN_W'(MAX_LEN);
            end else begin
                fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            fill_d = fill_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= DEFAULT_PATTERN;
            len_q     <= LEN_W'(DEFAULT_LEN);
            enabled_q <= len_legal(32'(DEFAULT_LEN), 32'(MAX_LEN));
            hist_q    <= '0;
            fill_q    <= '0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            enabled_q <= enabled_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
        end
    end

    assign enabled = enabled_q;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (match_s),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: directed bit streams with hand-computed
// expected match values pushed to a queue; a monitor pops one entry for every
// cycle with din_valid high and compares match on both a 16-bit and a 2-bit
// counter build.
module tb_seq_detect_param;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        overlap;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cnt_clr;
    logic        match;
    logic [15:0] match_cnt;
    logic        enabled;
    logic        match2;
    logic [1:0]  match_cnt2;
    logic        enabled2;

    int   n_vec;
    int   n_err;
    int   n_bit;
    logic exp_q[$];

    seq_detect_param dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .overlap     (overlap),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .enabled     (enabled)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .overlap     (overlap),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .match       (match2),
        .match_cnt   (match_cnt2),
        .enabled     (enabled2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected match value per presented bit.
    always @(negedge clk) begin
        if (din_valid === 1'b1) begin
            n_bit++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL match bit %0d: no expected value queued", n_bit);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk($sformatf("match bit %0d", n_bit), {31'd0, match}, {31'd0, e});
                chk($sformatf("match2 bit %0d", n_bit), {31'd0, match2}, {31'd0, e});
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send(input logic b, input logic e);
        din       = b;
        din_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // bits[n-1] is sent first.
    task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], exps[i]);
        end
    endtask

    // Idle cycles with din toggling to show it is ignored.
    task automatic idle(input int n);
        repeat (n) begin
            din = ~din;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic with_bit, input logic b);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        din         = b;
        din_valid   = with_bit;
        if (with_bit) begin
            exp_q.push_back(1'b0);
        end
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        n_bit       = 0;
        rst         = 1'b1;
        din         = 1'b0;
        din_valid   = 1'b0;
        overlap     = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cnt_clr     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset enabled", {31'd0, enabled}, 32'd1);
        chk("reset match", {31'd0, match}, 32'd0);
        chk("reset cnt", {16'd0, match_cnt}, 32'd0);
        chk("reset cnt2", {30'd0, match_cnt2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Default 1101, overlapping: matches on bits 4 and 7.
        overlap = 1'b1;
        send_seq(16'b1101101, 16'b0001001, 7);
        chk("ovl cnt", {16'd0, match_cnt}, 32'd2);
        chk("ovl cnt2", {30'd0, match_cnt2}, 32'd2);
        clr();
        chk("clr cnt", {16'd0, match_cnt}, 32'd0);

        // Non-overlapping: only bit 4 (history ...1101 gives no early hit).
        overlap = 1'b0;
        send_seq(16'b1101101, 16'b0001000, 7);
        chk("novl cnt", {16'd0, match_cnt}, 32'd1);

        // All-ones length 8.
        cfg(8'hFF, 4'd8, 1'b0, 1'b0);
        chk("len8 enabled", {31'd0, enabled}, 32'd1);
        overlap = 1'b1;
        send_seq(16'h01FF, 16'h0003, 9);
        chk("len8 ovl cnt", {16'd0, match_cnt}, 32'd3);
        chk("len8 ovl cnt2", {30'd0, match_cnt2}, 32'd3);
        cfg(8'hFF, 4'd8, 1'b0, 1'b0);
        overlap = 1'b0;
        send_seq(16'h01FF, 16'h0002, 9);
        chk("len8 novl cnt", {16'd0, match_cnt}, 32'd4);
        chk("cnt2 saturates", {30'd0, match_cnt2}, 32'd3);

        // din_valid gaps inside 1101.
        cfg(8'h0D, 4'd4, 1'b0, 1'b0);
        overlap = 1'b1;
        send(1'b1, 1'b0);
        idle(2);
        send(1'b1, 1'b0);
        idle(1);
        send(1'b0, 1'b0);
        idle(3);
        send(1'b1, 1'b1);
        chk("gap cnt", {16'd0, match_cnt}, 32'd5);

        // Config mid-sequence: the 1 in the cfg_we cycle is dropped, fill restarts.
        send_seq(16'b110, 16'b000, 3);
        cfg(8'h0D, 4'd4, 1'b1, 1'b1);
        send_seq(16'b101, 16'b000, 3);
        chk("midcfg cnt", {16'd0, match_cnt}, 32'd5);

        // Illegal lengths.
        cfg(8'h0D, 4'd0, 1'b0, 1'b0);
        chk("len0 enabled", {31'd0, enabled}, 32'd0);
        send_seq(16'b11011, 16'b00000, 5);
        cfg(8'hFF, 4'd9, 1'b0, 1'b0);
        chk("len9 enabled", {31'd0, enabled}, 32'd0);
        send_seq(16'b111, 16'b000, 3);

        // Length 1, pattern 1: match on every 1 in both modes.
        cfg(8'h01, 4'd1, 1'b0, 1'b0);
        chk("len1 enabled", {31'd0, enabled}, 32'd1);
        overlap = 1'b0;
        send_seq(16'b10110, 16'b10110, 5);
        overlap = 1'b1;
        send_seq(16'b11, 16'b11, 2);
        chk("len1 cnt", {16'd0, match_cnt}, 32'd10);
        chk("len1 cnt2", {30'd0, match_cnt2}, 32'd3);

        // cnt_clr concurrent with a match wins.
        cnt_clr = 1'b1;
        send(1'b1, 1'b1);
        cnt_clr = 1'b0;
        chk("clr+match cnt", {16'd0, match_cnt}, 32'd0);
        chk("clr+match cnt2", {30'd0, match_cnt2}, 32'd0);
        send(1'b1, 1'b1);
        chk("after clr cnt", {16'd0, match_cnt}, 32'd1);

        // Async reset mid-stream restores defaults immediately.
        cfg(8'hFF, 4'd0, 1'b0, 1'b0);
        chk("pre-rst enabled", {31'd0, enabled}, 32'd0);
        send_seq(16'b11, 16'b00, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst enabled", {31'd0, enabled}, 32'd1);
        chk("async rst cnt", {16'd0, match_cnt}, 32'd0);
        chk("async rst match", {31'd0, match}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        overlap = 1'b1;
        send_seq(16'b1101, 16'b0001, 4);
        chk("post-rst cnt", {16'd0, match_cnt}, 32'd1);

        chk("queue drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Programmable, parametrised serial bit-sequence detector: the next generation of the lab fixed 4-state Mealy detector. The pattern and its length (1..MAX_LEN) are loaded at run time. Overlapping or non-overlapping detection is selected by an input. A saturating match counter is kept. The block sits between a serial bit source (switch or debounced pushbutton path, or an upstream shifter) and display or LED logic.

## Interface
- MAX_LEN, 8, longest detectable pattern in bits (≥2)
- CNT_W, 16, width of match counter
- DEFAULT_PATTERN, 8'b0000_1101, pattern loaded at reset (low DEFAULT_LEN bits used)
- DEFAULT_LEN, 4, pattern length loaded at reset
- Derived: LEN_W = $clog2(MAX_LEN+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial data bit
- din_valid  in  1  din sampled only when high
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_we  in  1  load cfg_pattern/cfg_len this cycle
- cfg_pattern  in  MAX_LEN  new pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  new pattern length
- cnt_clr  in  1  synchronous clear of match_cnt
- match  out  1  Mealy output, combinational
- match_cnt  out  CNT_W  saturating count of matches
- enabled  out  1  registered; high when the loaded length is legal

## Operation
- Registers:
  - pat[MAX_LEN-1:0] and len[LEN_W-1:0]: the loaded configuration
  - hist[MAX_LEN-1:0]: previous bits, newest in bit 0
  - fill[LEN_W-1:0]: valid history bits, saturating at MAX_LEN
  - match_cnt
- Legal length: 1 ≤ len ≤ MAX_LEN. An illegal length sets enabled=0, and match stays 0.
- Candidate window: {hist, din}, using its low len bits.
- match = din_valid & enabled & !cfg_we & (fill ≥ len−1) & (window[len-1:0] == pat[len-1:0]).
- On an accepted bit (din_valid & !cfg_we):
  - hist ← {hist[MAX_LEN-2:0], din}
  - If match & !overlap: fill ← 0.
  - Otherwise: fill ← min(fill+1, MAX_LEN).
- overlap can change at any time. It takes effect on the next accepted bit.
- cfg_we:
  - pat ← cfg_pattern, len ← cfg_len, fill ← 0, enabled ← legal(cfg_len).
  - A din in the same cycle is dropped, and no match is produced.
- match_cnt priority:
  - cnt_clr: match_cnt ← 0. cnt_clr has priority, so a match in the same cycle is not counted.
  - Otherwise, on match: match_cnt increments, saturating at 2^CNT_W−1 with no wrap.
- Bits with din_valid=0 leave all state unchanged.

## Timing
- Reset (async assert, removal synchronous to clk):
  - pat = DEFAULT_PATTERN, len = DEFAULT_LEN, enabled = legal(DEFAULT_LEN)
  - hist = 0, fill = 0, match_cnt = 0
  - match = 0 (din_valid assumed 0, else it follows the equation, which yields 0 because fill = 0 and len > 1)
- match: zero latency, high in the same cycle as the final pattern bit. It is one cycle wide per match.
- match_cnt updates on the clock edge that ends the match cycle, so it is visible one cycle later.
- New configuration applies from the first accepted bit after the cfg_we edge. Detection requires len fresh bits.
- len = 1: match on every din equal to pat[0], in either mode.
- Reset mid-sequence discards partial history. No match can occur until len bits have been accepted after reset.

## Structure
- Package seq_detect_pkg:
  - function len_legal(len, max)
  - constant defaults (DEFAULT_PATTERN, DEFAULT_LEN)
  - typedef enum {NON_OVERLAP=0, OVERLAP=1} for the mode
- One sub-module: sat_counter (parameter W; inputs clr and inc; saturating output), used for match_cnt.
- Window compare is a masked equality: mask = (1<<len)−1. No per-pattern FSM is hand-coded.

## Test plan
- Reset defaults, pattern 1101 len 4, overlap=1:
  - Stream 1,1,0,1,1,0,1 → match on bits 4 and 7; match_cnt=2.
- Same stream, overlap=0 → match on bit 4 only; match_cnt=1.
- cfg_we with cfg_pattern=8'b1111_1111, cfg_len=8:
  - Stream nine 1s, overlap=1 → match on bits 8 and 9.
  - Same stream, overlap=0 → match on bit 8 only.
- Gaps and mid-sequence config:
  - din_valid gaps inside 1101 → still one match.
  - cfg_we asserted after 1,1,0 then 1 sent → no match. fill restarts, and that 1 is dropped.
- cfg_len=0 or cfg_len=9 → enabled=0; no match for any stream. Reload with len=1, pat=1 → match on every 1.
- Counter behaviour:
  - CNT_W=2 build, 5 matches → match_cnt saturates at 3.
  - cnt_clr concurrent with a match → match_cnt=0.
  - Async rst asserted mid-pattern → all outputs reset immediately.
